lut_block_accumulator: RTL
==========================

Name: lut_block_accumulator

Overview:
Downstream consumer of the LUT stage's `out` word and its `strobe` qualifier. Sums strobed samples over a programmable block length. Presents each block sum on a valid/ready output port. The block is double-buffered: a new block accumulates while the previous result waits for acceptance.

Parameters:
WIDTH, 8, width of the input sample; matches the upstream LUT `out` width.
LOG2_COUNT, 3, log2 of the maximum block length; maximum length is 2**LOG2_COUNT.
SUM_WIDTH, WIDTH+LOG2_COUNT, width of the block sum; sized so that a sum cannot overflow.

Ports:
clock  input  1  single clock; all logic on posedge.
reset  input  1  synchronous reset, active-high.
in  input  WIDTH  sample from the upstream LUT stage.
strobe  input  1  sample qualifier; `in` is consumed on every cycle this is high.
block_len  input  LOG2_COUNT+1  samples per block; 0 is treated as 1; values above 2**LOG2_COUNT saturate to 2**LOG2_COUNT.
flush  input  1  closes the current partial block.
out_sum  output  SUM_WIDTH  block sum.
out_count  output  LOG2_COUNT+1  number of samples in the presented block.
out_valid  output  1  result present.
out_ready  input  1  downstream accepts the result.
overflow  output  1  one-cycle pulse when a completed block is dropped.
drop_count  output  8  saturating count of dropped blocks.
busy  output  1  high while the accumulator holds at least one sample.

Behaviour:
- Reset (synchronous, any cycle, mid-block included):
  - out_sum=0, out_count=0, out_valid=0, overflow=0, drop_count=0, busy=0.
  - Accumulator, sample counter and latched length are cleared; any partial block is discarded.
- Accumulator side:
  - States are EMPTY and ACCUM.
  - EMPTY + strobe: latch effective block_len, acc=in, cnt=1, go to ACCUM.
  - If the latched length is 1, the block completes on that same strobe.
  - ACCUM + strobe: acc+=in (zero-extended to SUM_WIDTH), cnt+=1.
  - block_len changes are ignored until the next block starts.
- Completion:
  - A block completes when cnt reaches the latched length on a strobe cycle, or when flush is high while cnt>0 (after this cycle's strobe, if any).
  - A strobe coinciding with flush is included in the flushed block.
  - On completion the accumulator returns to EMPTY.
  - flush with cnt=0 and no strobe has no effect.
- Output register:
  - On completion, if out_valid=0, or out_valid=1 with out_ready=1 in the same cycle: load out_sum/out_count.
  - out_valid=1 from the next cycle.
  - Latency: result visible the cycle after the completing strobe/flush.
- Handshake:
  - out_valid && out_ready clears out_valid next cycle, unless a new completion reloads it that same cycle, in which case out_valid stays 1.
  - out_sum and out_count are stable while out_valid=1 and out_ready=0.
  - out_ready is ignored while out_valid=0.
- Drop:
  - Applies when a completion occurs while out_valid=1 and out_ready=0.
  - The new result is discarded and the held result is unchanged.
  - overflow=1 for exactly the next cycle; drop_count+=1, saturating at 255.
- busy = (state==ACCUM).
- Arithmetic is unsigned.
- Max sum (2**WIDTH-1)*2**LOG2_COUNT fits SUM_WIDTH exactly; no wrap.

Test Plan:
- Reset, then 5 idle cycles -> out_valid=0, out_sum=0, out_count=0, drop_count=0, busy=0 throughout.
- block_len=4, out_ready=1, strobes with in=1,2,3,4 on consecutive cycles -> next cycle out_valid=1, out_sum=10, out_count=4; out_valid=0 the cycle after.
- block_len=8, eight strobes of in=255 -> out_sum=2040, out_count=8, no wrap.
- block_len=2, out_ready=0, samples 3,4 then 5,6 -> first result (7) held; second block dropped, overflow pulse 1 cycle, drop_count=1; then out_ready=1 -> 7 accepted, out_valid drops.
- block_len=8, strobes 5,6, then strobe 7 with flush -> out_sum=18, out_count=3; a later flush with no samples produces no result.
- block_len=0, strobe in=9 -> out_sum=9, out_count=1.
- Reset asserted after 2 of 4 samples, then 4 fresh samples of in=1 -> only out_sum=4 is emitted.

Source files
------------

// File: rtl/lut_block_accumulator_if.sv
// Result port of the LUT block accumulator: block sum and sample count
// presented with a valid/ready handshake.
//   out_sum   : block sum            (master -> slave)
//   out_count : samples in the block (master -> slave)
//   out_valid : result present       (master -> slave)
//   out_ready : result accepted      (slave -> master)
interface lut_block_accumulator_if #(
  parameter int unsigned SUM_WIDTH = 11,
  parameter int unsigned CNT_WIDTH = 4
);
  logic [SUM_WIDTH-1:0] out_sum;
  logic [CNT_WIDTH-1:0] out_count;
  logic                 out_valid;
  logic                 out_ready;

  modport master (output out_sum, output out_count, output out_valid, input out_ready);
  modport slave  (input out_sum, input out_count, input out_valid, output out_ready);
endinterface

// File: rtl/lut_block_accumulator.sv
// Sums strobed LUT samples over a programmable block length and presents each
// block sum on a valid/ready port. A new block accumulates while the previous
// result waits; a block completing while the held result is stalled is dropped.
//   clock      : clock, all logic on posedge
//   reset      : synchronous active-high reset
//   in         : sample from the LUT stage
//   strobe     : sample qualifier
//   block_len  : samples per block (0 -> 1, saturates at 2**LOG2_COUNT)
//   flush      : close the current partial block
//   res        : result port (sum, count, valid/ready)
//   overflow   : one-cycle pulse when a completed block is dropped
//   drop_count : saturating count of dropped blocks
//   busy       : accumulator holds at least one sample
module lut_block_accumulator #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LOG2_COUNT = 3,
  parameter int unsigned SUM_WIDTH  = WIDTH + LOG2_COUNT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        in,
  input  logic                    strobe,
  input  logic [LOG2_COUNT:0]     block_len,
  input  logic                    flush,
  lut_block_accumulator_if.master res,
  output logic                    overflow,
  output logic [7:0]              drop_count,
  output logic                    busy
);

  localparam int unsigned CNT_WIDTH = LOG2_COUNT + 1;
  localparam logic [CNT_WIDTH-1:0] MAX_LEN = CNT_WIDTH'(1 << LOG2_COUNT);

  typedef enum logic {EMPTY, ACCUM} state_t;

  state_t               state, state_nxt;
  logic [SUM_WIDTH-1:0] acc_q, acc_nxt, acc_base;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_nxt, cnt_base;
  logic [CNT_WIDTH-1:0] len_q, cur_len, eff_len_c;
  logic                 done_c, load_c, drop_c;

  // Effective block length: 0 means 1, oversize values clamp to the maximum.
  always_comb begin
    eff_len_c = block_len;
    if (block_len == '0)
      eff_len_c = CNT_WIDTH'(1);
    else if (block_len > MAX_LEN)
      eff_len_c = MAX_LEN;
  end

  // Next accumulator contents and completion detect; a strobe that coincides
  // with flush is counted before the flush closes the block.
  always_comb begin
    state_nxt = state;
    acc_base  = acc_q;
    cnt_base  = cnt_q;
    cur_len   = len_q;
    if (state == EMPTY) begin
      acc_base = '0;
      cnt_base = '0;
      cur_len  = eff_len_c;
    end
    acc_nxt = acc_base;
    cnt_nxt = cnt_base;
    if (strobe) begin
      acc_nxt = acc_base + SUM_WIDTH'(in);
      cnt_nxt = cnt_base + CNT_WIDTH'(1);
    end
    done_c = (strobe && (cnt_nxt == cur_len)) || (flush && (cnt_nxt != '0));
    if (done_c)
      state_nxt = EMPTY;
    else if (cnt_nxt != '0)
      state_nxt = ACCUM;
    else
      state_nxt = EMPTY;
    load_c = done_c && (!res.out_valid || res.out_ready);
    drop_c = done_c && res.out_valid && !res.out_ready;
  end

  // State register and accumulator datapath.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= EMPTY;
      acc_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == EMPTY && strobe)
        len_q <= eff_len_c;
      if (done_c) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else begin
        acc_q <= acc_nxt;
        cnt_q <= cnt_nxt;
      end
    end
  end

  // Output holding register, handshake and drop accounting.
  always_ff @(posedge clock) begin
    if (reset) begin
      res.out_sum   <= '0;
      res.out_count <= '0;
      res.out_valid <= 1'b0;
      overflow      <= 1'b0;
      drop_count    <= 8'd0;
      busy          <= 1'b0;
    end else begin
      busy     <= (state_nxt == ACCUM);
      overflow <= drop_c;
      if (load_c) begin
        res.out_sum   <= acc_nxt;
        res.out_count <= cnt_nxt;
        res.out_valid <= 1'b1;
      end else if (res.out_valid && res.out_ready) begin
        res.out_valid <= 1'b0;
      end
      if (drop_c && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
    end
  end

endmodule
